// File: rtl/add8_eval_pkg.sv
// Shared widths and FSM encoding for the
// 8-bit approximate-adder error sweep.
package add8_eval_pkg;

  localparam int W         = 8;
  localparam int N_LOG2    = 2*W;
  localparam int SUM_W     = W+1;
  localparam int ERR_W     = W+2;
  localparam int ABS_ACC_W = 2*W+9;
  localparam int SQ_ACC_W  = 2*W+18;
  localparam int CNT_W     = 2*W+1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/add8_err_accum.sv
// Error stage: signed error, magnitude, square,
// and the four running error metrics.
module add8_err_accum
  import add8_eval_pkg::*;
#(
  parameter int W = add8_eval_pkg::W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic            v1,
  input  logic [W:0]      approx,
  input  logic [W:0]      exact,
  output logic [2*W+8:0]  sum_abs_err,
  output logic [2*W+17:0] sum_sq_err,
  output logic [W:0]      max_abs_err,
  output logic [2*W:0]    err_count
);

  localparam int EW   = W+2;
  localparam int SQW  = 2*W+2;
  localparam int ABSW = 2*W+9;
  localparam int SQAW = 2*W+18;
  localparam int CW   = 2*W+1;

  logic signed [EW-1:0] err;
  logic [EW-1:0]        mag;
  logic [W:0]           abs_err;
  logic [SQW-1:0]       sq_err;
  logic                 nz;

  always_comb begin
    err     = $signed({1'b0, approx})
            - $signed({1'b0, exact});
    mag     = err[EW-1] ? -err : err;
    abs_err = mag[W:0];
    nz      = |mag;
    sq_err  = SQW'(abs_err) * SQW'(abs_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_abs_err <= '0;
      sum_sq_err  <= '0;
      max_abs_err <= '0;
      err_count   <= '0;
    end else if (en) begin
      if (clr) begin
        sum_abs_err <= '0;
        sum_sq_err  <= '0;
        max_abs_err <= '0;
        err_count   <= '0;
      end else if (v1) begin
        sum_abs_err <= sum_abs_err + ABSW'(abs_err);
        sum_sq_err  <= sum_sq_err + SQAW'(sq_err);
        if (abs_err >= max_abs_err)
          max_abs_err <= abs_err;
        if (nz)
          err_count <= err_count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/add8_err_sweep.sv
// Exhaustive operand sweep driving an external adder,
// with error metrics accumulated over the sweep.
module add8_err_sweep
  import add8_eval_pkg::*;
#(
  parameter int W = add8_eval_pkg::W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            hold,
  output logic [W-1:0]    op_a,
  output logic [W-1:0]    op_b,
  input  logic [W:0]      approx_sum,
  output logic            busy,
  output logic            done,
  output logic [2*W+8:0]  sum_abs_err,
  output logic [2*W+17:0] sum_sq_err,
  output logic [W:0]      max_abs_err,
  output logic [2*W:0]    err_count,
  output logic            results_valid
);

  localparam int N = 2*W;

  state_e       state, state_n;
  logic [N-1:0] ctr;
  logic         v0, v1;
  logic [W:0]   s1_approx, s1_exact;
  logic         done_n;
  logic         go, issue;

  assign go    = start && (state == IDLE || state == DONE);
  assign issue = (state == RUN);
  // Busy drops on the last drain cycle, once the pipe is empty.
  assign busy  = issue || (state == DRAIN && (v0 || v1));

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    unique case (state)
      IDLE, DONE: if (start) state_n = RUN;
      RUN:        if (&ctr) state_n = DRAIN;
      DRAIN: begin
        if (!v0 && !v1) begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ctr           <= '0;
      op_a          <= '0;
      op_b          <= '0;
      v0            <= 1'b0;
      v1            <= 1'b0;
      s1_approx     <= '0;
      s1_exact      <= '0;
      done          <= 1'b0;
      results_valid <= 1'b0;
    end else if (!hold) begin
      state     <= state_n;
      done      <= done_n;
      v0        <= issue;
      v1        <= v0;
      s1_approx <= approx_sum;
      s1_exact  <= {1'b0, op_a} + {1'b0, op_b};
      if (go)
        ctr <= '0;
      else if (issue)
        ctr <= ctr + N'(1);
      if (issue)
        {op_a, op_b} <= ctr;
      if (done_n)
        results_valid <= 1'b1;
      else if (go)
        results_valid <= 1'b0;
    end
  end

  add8_err_accum #(
    .W (W)
  ) u_accum (
    .clk         (clk),
    .rst         (rst),
    .en          (!hold),
    .clr         (go),
    .v1          (v1),
    .approx      (s1_approx),
    .exact       (s1_exact),
    .sum_abs_err (sum_abs_err),
    .sum_sq_err  (sum_sq_err),
    .max_abs_err (max_abs_err),
    .err_count   (err_count)
  );

endmodule
